// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: pass/SLL/SRL/SRA (+ROL/ROR with SHIFTER_ROTATE_EN).
// Shift levels are spread over STAGES registers with valid/ready back-pressure.
module pipelined_shifter #(
    parameter  int WORD_SIZE = 32,
    parameter  int STAGES    = 2,
    localparam int SH_W      = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           H,
    input  logic [WORD_SIZE-1:0] B,
    input  logic [SH_W-1:0]      SH,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] S_Result,
    output logic                 S_Zero,
    output logic                 S_Err
);

    localparam int LPS = (SH_W + STAGES - 1) / STAGES;

    localparam logic [2:0] M_PASS = 3'b000;
    localparam logic [2:0] M_SLL  = 3'b001;
    localparam logic [2:0] M_SRL  = 3'b010;
    localparam logic [2:0] M_SRA  = 3'b011;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
`endif

    // Applies levels lo .. lo+LPS-1 of the barrel shift selected by sh.
    function automatic logic [WORD_SIZE-1:0] shift_lv(
        input logic [WORD_SIZE-1:0] d,
        input logic [2:0]           m,
        input logic [SH_W-1:0]      sh,
        input int                   lo
    );
        logic [WORD_SIZE-1:0] r;
        logic [SH_W-1:0]      bit_l;
        r = d;
        for (int l = 0; l < SH_W; l++) begin
            bit_l = SH_W'(1) << l;
            if (l >= lo && l < lo + LPS && (sh & bit_l) != '0) begin
                case (m)
                    M_SLL:   r = r << (1 << l);
                    M_SRL:   r = r >> (1 << l);
                    M_SRA:   r = $signed(r) >>> (1 << l);
`ifdef SHIFTER_ROTATE_EN
                    M_ROL:   r = (r << (1 << l)) | (r >> (WORD_SIZE - (1 << l)));
                    M_ROR:   r = (r >> (1 << l)) | (r << (WORD_SIZE - (1 << l)));
`endif
                    default: r = r;
                endcase
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0]    vld;
    logic [STAGES-1:0]    err;
    logic [STAGES-1:0]    adv;
    logic [2:0]           mode [STAGES];
    logic [SH_W-1:0]      sh   [STAGES];
    logic [WORD_SIZE-1:0] data [STAGES];

    logic       in_err;
    logic [2:0] in_mode;

    // Classify the incoming mode; illegal beats travel as a zeroed pass.
    always_comb begin
        in_err  = 1'b0;
        in_mode = H;
`ifdef SHIFTER_ROTATE_EN
        in_err  = H[2] & H[1];
`else
        in_err  = H[2];
`endif
        if (in_err) begin
            in_mode = M_PASS;
        end
    end

    // A stage advances if any stage from it to the output is empty or the sink takes the beat.
    always_comb begin : adv_chain
        logic free;
        free = out_ready;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free   = free || !vld[k];
            adv[k] = free;
        end
    end

    // Stage registers; stage k holds data with levels of stages 0..k-1 applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            err <= '0;
            for (int k = 0; k < STAGES; k++) begin
                mode[k] <= '0;
                sh[k]   <= '0;
                data[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= in_err ? '0 : B;
                    mode[0] <= in_mode;
                    sh[0]   <= SH;
                    err[0]  <= in_err;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        data[k] <= shift_lv(data[k-1], mode[k-1], sh[k-1], (k - 1) * LPS);
                        mode[k] <= mode[k-1];
                        sh[k]   <= sh[k-1];
                        err[k]  <= err[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign S_Err     = err[STAGES-1];
    assign S_Result  = shift_lv(data[STAGES-1], mode[STAGES-1], sh[STAGES-1],
                                (STAGES - 1) * LPS);
    assign S_Zero    = out_valid && (S_Result == '0);

endmodule
